// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: byte-level command responder between a UART host and the
// internal 16-bit-address / 8-bit-data memory bus. Commands are 'R' (read)
// and 'W' (write). Any other first byte is answered with NAK_BYTE. All logic
// runs on the UART bit clock, so no synchronisers are needed.
// Optional feature: define UART_MEM_BRIDGE_BURST_EN to add the 'B' burst-read
// command (ADDR_HI, ADDR_LO, COUNT; COUNT=0 means 256 bytes).

module uart_mem_bridge #(
    parameter int         TIMEOUT_CYCLES = 1152,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
    input  logic        clock115200,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_recv,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        busy,
    output logic        overrun
);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
`ifdef UART_MEM_BRIDGE_BURST_EN
    localparam logic [7:0] CMD_BURST = 8'h42;
`endif

    localparam int            TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WDATA,
        S_BUS,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t        r_state;
    logic          r_cmdWrite;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;
    logic [7:0]    r_resp;
    logic [7:0]    r_txData;
    logic          r_txSend;
    logic          r_txLow;
    logic          r_memReq;
    logic          r_memWe;
    logic [TW-1:0] r_timer;
    logic          r_overrun;
`ifdef UART_MEM_BRIDGE_BURST_EN
    logic          r_cmdBurst;
    logic [7:0]    r_remaining;
`endif

    logic w_timeout;
    logic w_rxBlocked;

    assign w_timeout   = (r_timer == TIMEOUT_LAST);
    assign w_rxBlocked = rx_recv && ((r_state == S_BUS) || (r_state == S_SEND) || (r_state == S_WAIT_TX));

    assign tx_data   = r_txData;
    assign tx_send   = r_txSend;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign busy      = (r_state != S_IDLE);
    assign overrun   = r_overrun;

    // Command parser, bus master and transmit handshake in one registered FSM.
    always_ff @(posedge clock115200) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cmdWrite <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_resp     <= '0;
            r_txData   <= '0;
            r_txSend   <= 1'b0;
            r_txLow    <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_timer    <= '0;
            r_overrun  <= 1'b0;
`ifdef UART_MEM_BRIDGE_BURST_EN
            r_cmdBurst  <= 1'b0;
            r_remaining <= '0;
`endif
        end else begin
            if (w_rxBlocked) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (rx_recv) begin
`ifdef UART_MEM_BRIDGE_BURST_EN
                        r_cmdBurst <= 1'b0;
`endif
                        if (rx_data == CMD_READ) begin
                            r_cmdWrite <= 1'b0;
                            r_state    <= S_ADDR_HI;
                        end else if (rx_data == CMD_WRITE) begin
                            r_cmdWrite <= 1'b1;
                            r_state    <= S_ADDR_HI;
`ifdef UART_MEM_BRIDGE_BURST_EN
                        end else if (rx_data == CMD_BURST) begin
                            r_cmdWrite <= 1'b0;
                            r_cmdBurst <= 1'b1;
                            r_state    <= S_ADDR_HI;
`endif
                        end else begin
                            r_resp  <= NAK_BYTE;
                            r_state <= S_SEND;
                        end
                    end
                end

                S_ADDR_HI: begin
                    if (rx_recv) begin
                        r_addr[15:8] <= rx_data;
                        r_timer      <= '0;
                        r_state      <= S_ADDR_LO;
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_ADDR_LO: begin
                    if (rx_recv) begin
                        r_addr[7:0] <= rx_data;
                        r_timer     <= '0;
`ifdef UART_MEM_BRIDGE_BURST_EN
                        if (r_cmdWrite || r_cmdBurst) begin
`else
                        if (r_cmdWrite) begin
`endif
                            r_state <= S_WDATA;
                        end else begin
                            r_memReq <= 1'b1;
                            r_memWe  <= 1'b0;
                            r_state  <= S_BUS;
                        end
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_WDATA: begin
                    if (rx_recv) begin
`ifdef UART_MEM_BRIDGE_BURST_EN
                        if (r_cmdBurst) begin
                            r_remaining <= rx_data;
                        end else begin
                            r_wdata <= rx_data;
                        end
`else
                        r_wdata <= rx_data;
`endif
                        r_timer  <= '0;
                        r_memReq <= 1'b1;
                        r_memWe  <= r_cmdWrite;
                        r_state  <= S_BUS;
                    end else if (w_timeout) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_BUS: begin
                    if (mem_ack && r_memReq) begin
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                        r_resp   <= r_cmdWrite ? ACK_BYTE : mem_rdata;
`ifdef UART_MEM_BRIDGE_BURST_EN
                        if (r_cmdBurst) begin
                            r_addr <= r_addr + 16'd1;
                        end
`endif
                        r_state  <= S_SEND;
                    end
                end

                S_SEND: begin
                    if (tx_ready) begin
                        r_txData <= r_resp;
                        r_txSend <= 1'b1;
                        r_txLow  <= 1'b0;
                        r_state  <= S_WAIT_TX;
                    end
                end

                S_WAIT_TX: begin
                    if (!tx_ready) begin
                        r_txSend <= 1'b0;
                        r_txLow  <= 1'b1;
                    end else if (r_txLow) begin
`ifdef UART_MEM_BRIDGE_BURST_EN
                        if (r_cmdBurst && (r_remaining != 8'd1)) begin
                            r_remaining <= r_remaining - 8'd1;
                            r_memReq    <= 1'b1;
                            r_memWe     <= 1'b0;
                            r_state     <= S_BUS;
                        end else begin
                            r_state <= S_IDLE;
                        end
`else
                        r_state <= S_IDLE;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: table-driven and randomized checks of uart_mem_bridge
// against a command-level reference model, a behavioural bus slave and a
// behavioural UART transmitter.

module tb_uart_mem_bridge;

    logic        clock115200 = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_recv;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        busy;
    logic        overrun;

    uart_mem_bridge dut (
        .clock115200 (clock115200),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_recv     (rx_recv),
        .tx_data     (tx_data),
        .tx_send     (tx_send),
        .tx_ready    (tx_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .busy        (busy),
        .overrun     (overrun)
    );

    // Free-running bit clock.
    always #5 clock115200 = ~clock115200;

    // Cycle counter used for latency measurements.
    int cyc = 0;
    always @(posedge clock115200) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } busAcc_t;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [7:0]  expTx;
        int          expBus;
        logic [15:0] expAddr;
        logic        expWe;
        logic [7:0]  expWdata;
    } vec_t;

    int          nChecks = 0;
    int          nPass = 0;
    logic [7:0]  busMem [65536];
    logic [7:0]  refMem [65536];
    busAcc_t     busLog[$];
    logic [7:0]  txLog[$];
    int          busDelay = 3;
    int          txFrameLen = 8;
    bit          txHold = 1'b0;
    bit          spuriousAck = 1'b0;
    int          busUnstable = 0;
    int          txUnstable = 0;
    int          lastAckCyc = 0;
    int          lastSendCyc = 0;

    // Behavioural memory slave: acks each request after a delay and logs it.
    initial begin : busSlave
        bit      active;
        int      waitLeft;
        busAcc_t cur;
        active   = 1'b0;
        waitLeft = 0;
        mem_ack  = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clock115200);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (mem_req === 1'b1) begin
                if (!active) begin
                    active    = 1'b1;
                    cur.addr  = mem_addr;
                    cur.we    = mem_we;
                    cur.wdata = mem_wdata;
                    waitLeft  = (busDelay < 0) ? int'($urandom_range(0, 5)) : busDelay;
                end else if (mem_addr !== cur.addr || mem_we !== cur.we ||
                             (cur.we && mem_wdata !== cur.wdata)) begin
                    busUnstable++;
                end
                if (waitLeft == 0) begin
                    busLog.push_back(cur);
                    if (cur.we) busMem[cur.addr] = cur.wdata;
                    else        mem_rdata = busMem[cur.addr];
                    mem_ack    = 1'b1;
                    active     = 1'b0;
                    lastAckCyc = cyc;
                end else begin
                    waitLeft--;
                end
            end else begin
                active = 1'b0;
                if (spuriousAck && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
            end
        end
    end

    // Behavioural UART transmitter: takes a byte on send, stays busy for a frame.
    initial begin : txModel
        bit         inFrame;
        int         left;
        logic [7:0] fb;
        inFrame  = 1'b0;
        left     = 0;
        fb       = 8'h00;
        tx_ready = 1'b1;
        forever begin
            @(negedge clock115200);
            if (inFrame) begin
                if (tx_data !== fb) txUnstable++;
                if (left == 0) begin
                    if (tx_send !== 1'b0) txUnstable++;
                    inFrame  = 1'b0;
                    tx_ready = !txHold;
                end else begin
                    left--;
                end
            end else if (tx_send === 1'b1 && tx_ready) begin
                fb          = tx_data;
                txLog.push_back(fb);
                lastSendCyc = cyc;
                inFrame     = 1'b1;
                left        = (txFrameLen < 0) ? int'($urandom_range(2, 12)) : txFrameLen;
                tx_ready    = 1'b0;
            end else begin
                tx_ready = !txHold;
            end
        end
    end

    // Hard stop in case some bounded wait logic itself goes wrong.
    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int g;
        @(negedge clock115200);
        rx_data = b;
        rx_recv = 1'b1;
        @(negedge clock115200);
        rx_recv = 1'b0;
        rx_data = 8'($urandom);
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) @(negedge clock115200);
    endtask

    task automatic waitTx(input int n, input int budget, input string name);
        int k = 0;
        while (txLog.size() < n && k < budget) begin
            @(negedge clock115200);
            k++;
        end
        checkOutput({name, "_txArrived"}, 32'(txLog.size() >= n), 32'd1);
    endtask

    task automatic waitIdle(input int budget, input string name);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clock115200);
            k++;
        end
        checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic runCmd(input vec_t v, input string name, input int gap);
        logic [7:0] gotTx;
        busAcc_t    acc;
        busLog.delete();
        txLog.delete();
        for (int i = 0; i < v.n; i++) applyStimulus(v.bytes[31 - 8 * i -: 8], gap);
        waitTx(1, 300, name);
        waitIdle(300, name);
        repeat (3) @(negedge clock115200);
        gotTx = (txLog.size() > 0) ? txLog[0] : 8'hxx;
        checkOutput({name, "_txCount"}, 32'(txLog.size()), 32'd1);
        checkOutput({name, "_txByte"}, 32'(gotTx), 32'(v.expTx));
        checkOutput({name, "_busCount"}, 32'(busLog.size()), 32'(v.expBus));
        if (v.expBus > 0 && busLog.size() > 0) begin
            acc = busLog[0];
            checkOutput({name, "_addr"}, 32'(acc.addr), 32'(v.expAddr));
            checkOutput({name, "_we"}, 32'(acc.we), 32'(v.expWe));
            if (v.expWe) checkOutput({name, "_wdata"}, 32'(acc.wdata), 32'(v.expWdata));
            checkOutput({name, "_latency"}, 32'(lastSendCyc - lastAckCyc), 32'd2);
        end
    endtask

    vec_t vecTable[6];

    initial begin : main
        vec_t        v;
        int          kind;
        int          sendSeen;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  u;

        vecTable[0] = '{32'h52123400, 3, 8'hA5, 1, 16'h1234, 1'b0, 8'h00};
        vecTable[1] = '{32'h57C0005A, 4, 8'h4B, 1, 16'hC000, 1'b1, 8'h5A};
        vecTable[2] = '{32'h00000000, 1, 8'h3F, 0, 16'h0000, 1'b0, 8'h00};
        vecTable[3] = '{32'h52000100, 3, 8'h3C, 1, 16'h0001, 1'b0, 8'h00};
        vecTable[4] = '{32'h52C00000, 3, 8'h5A, 1, 16'hC000, 1'b0, 8'h00};
        vecTable[5] = '{32'h57ABCD00, 4, 8'h4B, 1, 16'hABCD, 1'b1, 8'h00};

        for (int i = 0; i < 65536; i++) begin
            busMem[i] = 8'(i * 7 + 3);
            refMem[i] = 8'(i * 7 + 3);
        end
        busMem[16'h1234] = 8'hA5;
        busMem[16'h0001] = 8'h3C;

        // Reset state
        reset   = 1'b1;
        rx_recv = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(negedge clock115200);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock115200);

        // Directed command vectors
        for (int i = 0; i < 6; i++) runCmd(vecTable[i], $sformatf("vec%0d", i), 1);

        // Timeout: incomplete command abandoned silently
        busLog.delete();
        txLog.delete();
        applyStimulus(8'h52, 2);
        applyStimulus(8'h12, 2);
        repeat (1100) @(negedge clock115200);
        checkOutput("to_stillBusy", 32'(busy), 32'd1);
        repeat (60) @(negedge clock115200);
        checkOutput("to_idle", 32'(busy), 32'd0);
        checkOutput("to_noTx", 32'(txLog.size()), 32'd0);
        checkOutput("to_noBus", 32'(busLog.size()), 32'd0);
        v = '{32'h570000FF, 4, 8'h4B, 1, 16'h0000, 1'b1, 8'hFF};
        runCmd(v, "to_after", 1);

        // Transmit handshake held off, with a byte injected during SEND
        txHold = 1'b1;
        busLog.delete();
        txLog.delete();
        applyStimulus(8'h52, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'h34, 1);
        sendSeen = 0;
        for (int i = 0; i < 50 && busLog.size() == 0; i++) @(negedge clock115200);
        checkOutput("hs_busDone", 32'(busLog.size()), 32'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock115200);
            if (tx_send) sendSeen++;
            if (i == 10) begin
                rx_data = 8'h57;
                rx_recv = 1'b1;
            end else begin
                rx_recv = 1'b0;
            end
        end
        checkOutput("hs_noSendWhileBusy", 32'(sendSeen), 32'd0);
        checkOutput("hs_overrun", 32'(overrun), 32'd1);
        checkOutput("hs_busyInSend", 32'(busy), 32'd1);
        txHold = 1'b0;
        waitTx(1, 100, "hs");
        waitIdle(100, "hs");
        repeat (5) @(negedge clock115200);
        checkOutput("hs_txByte", 32'((txLog.size() > 0) ? txLog[0] : 8'hxx), 32'h0A5);
        checkOutput("hs_droppedByte", 32'(busy), 32'd0);
        checkOutput("hs_overrunSticky", 32'(overrun), 32'd1);
        checkOutput("hs_oneBus", 32'(busLog.size()), 32'd1);
        reset = 1'b1;
        @(negedge clock115200);
        checkOutput("hs_overrunCleared", 32'(overrun), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a bus access
        busDelay = 30;
        busLog.delete();
        txLog.delete();
        applyStimulus(8'h52, 1);
        applyStimulus(8'h12, 1);
        applyStimulus(8'h34, 1);
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clock115200);
        checkOutput("rm_reqSeen", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clock115200);
        checkOutput("rm_reqDropped", 32'(mem_req), 32'd0);
        checkOutput("rm_sendLow", 32'(tx_send), 32'd0);
        checkOutput("rm_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        busDelay = 3;
        repeat (40) @(negedge clock115200);
        checkOutput("rm_noBus", 32'(busLog.size()), 32'd0);
        checkOutput("rm_noTx", 32'(txLog.size()), 32'd0);
        applyStimulus(8'h57, 1);
        applyStimulus(8'hAA, 1);
        reset = 1'b1;
        @(negedge clock115200);
        reset = 1'b0;
        runCmd(vecTable[3], "rm_partialDiscarded", 1);

        // Burst command, or its rejection when the feature is absent
        busMem[16'hFFFE] = 8'h11;
        busMem[16'hFFFF] = 8'h22;
        busMem[16'h0000] = 8'h33;
        busLog.delete();
        txLog.delete();
`ifdef UART_MEM_BRIDGE_BURST_EN
        applyStimulus(8'h42, 1);
        applyStimulus(8'hFF, 1);
        applyStimulus(8'hFE, 1);
        applyStimulus(8'h03, 1);
        waitTx(3, 400, "burst");
        waitIdle(100, "burst");
        repeat (5) @(negedge clock115200);
        checkOutput("burst_txCount", 32'(txLog.size()), 32'd3);
        checkOutput("burst_busCount", 32'(busLog.size()), 32'd3);
        if (txLog.size() == 3 && busLog.size() == 3) begin
            checkOutput("burst_tx0", 32'(txLog[0]), 32'h11);
            checkOutput("burst_tx1", 32'(txLog[1]), 32'h22);
            checkOutput("burst_tx2", 32'(txLog[2]), 32'h33);
            checkOutput("burst_addr0", 32'(busLog[0].addr), 32'hFFFE);
            checkOutput("burst_addr1", 32'(busLog[1].addr), 32'hFFFF);
            checkOutput("burst_addr2", 32'(busLog[2].addr), 32'h0000);
            checkOutput("burst_we", 32'({busLog[0].we, busLog[1].we, busLog[2].we}), 32'd0);
        end
`else
        applyStimulus(8'h42, 1);
        waitTx(1, 100, "noburst0");
        waitIdle(100, "noburst0");
        applyStimulus(8'hFF, 1);
        waitTx(2, 100, "noburst1");
        waitIdle(100, "noburst1");
        applyStimulus(8'hFE, 1);
        waitTx(3, 100, "noburst2");
        waitIdle(100, "noburst2");
        applyStimulus(8'h03, 1);
        waitTx(4, 100, "noburst3");
        waitIdle(100, "noburst3");
        repeat (5) @(negedge clock115200);
        checkOutput("noburst_txCount", 32'(txLog.size()), 32'd4);
        checkOutput("noburst_busCount", 32'(busLog.size()), 32'd0);
        for (int i = 0; i < 4 && i < txLog.size(); i++)
            checkOutput($sformatf("noburst_tx%0d", i), 32'(txLog[i]), 32'h3F);
`endif

        // Randomized commands against the command-level model
        busDelay    = -1;
        txFrameLen  = -1;
        spuriousAck = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            a    = 16'h8000 | 16'($urandom_range(0, 15));
            d    = 8'($urandom);
            if (kind == 0) begin
                v = '{{8'h52, a, 8'h00}, 3, refMem[a], 1, a, 1'b0, 8'h00};
            end else if (kind == 1) begin
                refMem[a] = d;
                v = '{{8'h57, a, d}, 4, 8'h4B, 1, a, 1'b1, d};
            end else begin
                u = 8'($urandom);
`ifdef UART_MEM_BRIDGE_BURST_EN
                while (u == 8'h52 || u == 8'h57 || u == 8'h42) u = 8'($urandom);
`else
                while (u == 8'h52 || u == 8'h57) u = 8'($urandom);
`endif
                v = '{{u, 24'h000000}, 1, 8'h3F, 0, 16'h0000, 1'b0, 8'h00};
            end
            runCmd(v, $sformatf("rnd%0d", it), -1);
        end
        spuriousAck = 1'b0;
        repeat (5) @(negedge clock115200);

        checkOutput("busStable", 32'(busUnstable), 32'd0);
        checkOutput("txStable", 32'(txUnstable), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
